// File: rtl/fpu_dispatch.sv
// Command sequencer for the FPU path: issues one operation at a time to one of NUM_UNITS
// AXI-stream operator units and returns the unit's result, or an error code, on a response port.
module fpu_dispatch #(
    parameter int                   DW         = 64,
    parameter int                   NUM_UNITS  = 4,
    parameter int                   OPW        = 3,
    parameter logic [NUM_UNITS-1:0] UNARY_MASK = 4'b0011,
    parameter int                   TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPW-1:0]          cmd_op,
    input  logic [DW-1:0]           cmd_a,
    input  logic [DW-1:0]           cmd_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DW-1:0]           rsp_data,
    output logic [1:0]              rsp_err,
    output logic                    idle,
    output logic [NUM_UNITS*DW-1:0] u_a_tdata,
    output logic [NUM_UNITS-1:0]    u_a_tvalid,
    input  logic [NUM_UNITS-1:0]    u_a_tready,
    output logic [NUM_UNITS*DW-1:0] u_b_tdata,
    output logic [NUM_UNITS-1:0]    u_b_tvalid,
    input  logic [NUM_UNITS-1:0]    u_b_tready,
    input  logic [NUM_UNITS*DW-1:0] u_r_tdata,
    input  logic [NUM_UNITS-1:0]    u_r_tvalid,
    output logic [NUM_UNITS-1:0]    u_r_tready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_OP  = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]           state;
    logic [NUM_UNITS-1:0] sel_oh;
    logic [NUM_UNITS-1:0] op_dec;
    logic                 a_pend;
    logic                 b_pend;
    logic [DW-1:0]        a_q;
    logic [DW-1:0]        b_q;
    logic [DW-1:0]        r_data;
    logic [CW-1:0]        tcnt;
    logic                 in_send;
    logic                 a_hs;
    logic                 b_hs;
    logic                 r_hs;
    logic                 send_done;
    logic                 tmo;

    // One-hot unit select; an all-zero result marks an opcode outside 1..NUM_UNITS.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op_dec = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            op_dec[i] = (cmd_op == OPW'(i + 1));
        end
    end

    always_comb begin
        r_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel_oh[i]) begin
                r_data = r_data | u_r_tdata[i*DW +: DW];
            end
        end
    end

    assign in_send    = (state == S_SEND);
    assign cmd_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign idle       = cmd_ready & ~cmd_valid;

    assign u_a_tvalid = sel_oh & {NUM_UNITS{in_send & a_pend}};
    assign u_b_tvalid = sel_oh & {NUM_UNITS{in_send & b_pend}};
    assign u_r_tready = sel_oh & {NUM_UNITS{state == S_WAIT}};

    // Data follows valid so unselected or idle units always see zero.
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        assign u_a_tdata[g*DW +: DW] = u_a_tvalid[g] ? a_q : '0;
        assign u_b_tdata[g*DW +: DW] = u_b_tvalid[g] ? b_q : '0;
    end

    assign a_hs      = |(u_a_tvalid & u_a_tready);
    assign b_hs      = |(u_b_tvalid & u_b_tready);
    assign r_hs      = |(u_r_tvalid & u_r_tready);
    assign send_done = (~a_pend | a_hs) & (~b_pend | b_hs);
    assign tmo       = (TIMEOUT != 0) && (tcnt == T_LAST);

    // NOTE: operand registers carry no reset; they are only read after being loaded on accept.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && cmd_valid) begin
            a_q <= cmd_a;
            b_q <= cmd_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sel_oh   <= '0;
            a_pend   <= 1'b0;
            b_pend   <= 1'b0;
            tcnt     <= '0;
            rsp_data <= '0;
            rsp_err  <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sel_oh <= op_dec;
                        tcnt   <= '0;
                        if (|op_dec) begin
                            state  <= S_SEND;
                            a_pend <= 1'b1;
                            b_pend <= ~|(op_dec & UNARY_MASK);
                        end else begin
                            state    <= S_RESP;
                            rsp_data <= '0;
                            rsp_err  <= ERR_OP;
                        end
                    end
                end
                S_SEND: begin
                    tcnt <= tcnt + 1'b1;
                    if (a_hs) a_pend <= 1'b0;
                    if (b_hs) b_pend <= 1'b0;
                    if (tmo) begin
                        state    <= S_RESP;
                        a_pend   <= 1'b0;
                        b_pend   <= 1'b0;
                        rsp_data <= '0;
                        rsp_err  <= ERR_TMO;
                    end else if (send_done) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // A result arriving on the last allowed cycle still wins over the timeout.
                    if (r_hs) begin
                        state    <= S_RESP;
                        rsp_data <= r_data;
                        rsp_err  <= ERR_OK;
                    end else if (tmo) begin
                        state    <= S_RESP;
                        rsp_data <= '0;
                        rsp_err  <= ERR_TMO;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: four modelled operator units, a vector table,
// randomized traffic against a reference model, and hand-written stall/timeout/reset sequences.
module tb_fpu_dispatch;

    localparam logic [3:0] TB_UNARY = 4'b0011;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic [1:0]  e;
        int          lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [63:0]  cmd_a;
    logic [63:0]  cmd_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic [1:0]   rsp_err;
    logic         idle;
    logic [255:0] u_a_tdata;
    logic [3:0]   u_a_tvalid;
    bit   [3:0]   u_a_tready;
    logic [255:0] u_b_tdata;
    logic [3:0]   u_b_tvalid;
    bit   [3:0]   u_b_tready;
    bit   [255:0] u_r_tdata;
    bit   [3:0]   u_r_tvalid;
    logic [3:0]   u_r_tready;

    int n_cmp = 0;
    int n_bad = 0;

    // Unit-model controls and state
    bit          rand_mode = 1'b0;
    int          b_lo = 0;
    bit   [3:0]  r_en = 4'hF;
    bit          have_a [4];
    bit          have_b [4];
    bit          hs_a [4];
    bit          hs_b [4];
    bit          hs_r [4];
    logic [63:0] opa [4];
    logic [63:0] opb [4];
    logic [63:0] cap_a [4];
    logic [63:0] cap_b [4];
    int          bw [4];
    int          lo_a [4];
    int          lo_b [4];
    int          lo_r [4];
    bit          ra;
    bit          rb;
    bit          go;

    // Protocol monitor state
    int    exp_unit = -1;
    bit    exp_unary = 1'b0;
    int    viol = 0;
    string viol_msg = "";

    // Per-operation trace filled in by do_op
    int a_cyc;
    int b_cyc;
    int r_first;
    int bstab_bad;

    fpu_dispatch #(
        .DW(64), .NUM_UNITS(4), .OPW(3), .UNARY_MASK(4'b0011), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .idle(idle),
        .u_a_tdata(u_a_tdata), .u_a_tvalid(u_a_tvalid), .u_a_tready(u_a_tready),
        .u_b_tdata(u_b_tdata), .u_b_tvalid(u_b_tvalid), .u_b_tready(u_b_tready),
        .u_r_tdata(u_r_tdata), .u_r_tvalid(u_r_tvalid), .u_r_tready(u_r_tready)
    );

    always #5 clk = ~clk;

    // What each operator unit computes
    function automatic logic [63:0] unit_fn(input int i, input logic [63:0] a, input logic [63:0] b);
        case (i)
            0:       return a + 64'd1;
            1:       return ~a;
            2:       return $realtobits($bitstoreal(a) * $bitstoreal(b));
            default: return a ^ b;
        endcase
    endfunction

    // Reference model of a whole operation: routing plus error rules
    task automatic ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] d, output logic [1:0] e);
        if (op >= 3'd1 && op <= 3'd4) begin
            d = unit_fn(int'(op) - 1, a, b);
            e = 2'd0;
        end else begin
            d = 64'd0;
            e = 2'd1;
        end
    endtask

    function automatic bit gate(input int lo);
        return (lo >= 2) || ($urandom_range(0, 3) != 0);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Operator units: drive readys/results after the falling edge, record handshakes before the rising edge
    always @(negedge clk) begin
        #1;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                have_a[i] = 1'b0; have_b[i] = 1'b0;
                hs_a[i] = 1'b0; hs_b[i] = 1'b0; hs_r[i] = 1'b0;
                bw[i] = 0; lo_a[i] = 0; lo_b[i] = 0; lo_r[i] = 0;
            end
            u_a_tready = '0;
            u_b_tready = '0;
            u_r_tvalid = '0;
            u_r_tdata  = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (hs_a[i]) begin have_a[i] = 1'b1; opa[i] = cap_a[i]; end
                if (hs_b[i]) begin have_b[i] = 1'b1; opb[i] = cap_b[i]; end
                if (hs_r[i]) u_r_tvalid[i] = 1'b0;
                go = !rand_mode || gate(lo_r[i]);
                lo_r[i] = go ? 0 : lo_r[i] + 1;
                if (!u_r_tvalid[i] && have_a[i] && (TB_UNARY[i] || have_b[i]) && r_en[i] && go) begin
                    u_r_tvalid[i] = 1'b1;
                    u_r_tdata[i*64 +: 64] = unit_fn(i, opa[i], opb[i]);
                    have_a[i] = 1'b0;
                    have_b[i] = 1'b0;
                end
                ra = !rand_mode || gate(lo_a[i]);
                lo_a[i] = ra ? 0 : lo_a[i] + 1;
                rb = !rand_mode || gate(lo_b[i]);
                lo_b[i] = rb ? 0 : lo_b[i] + 1;
                if (u_b_tvalid[i]) begin
                    if (bw[i] < b_lo) rb = 1'b0;
                    bw[i]++;
                end else begin
                    bw[i] = 0;
                end
                u_a_tready[i] = ra;
                u_b_tready[i] = rb;
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                hs_a[i]  = u_a_tvalid[i] && u_a_tready[i];
                hs_b[i]  = u_b_tvalid[i] && u_b_tready[i];
                hs_r[i]  = u_r_tvalid[i] && u_r_tready[i];
                cap_a[i] = u_a_tdata[i*64 +: 64];
                cap_b[i] = u_b_tdata[i*64 +: 64];
            end
        end
    end

    // Only the addressed unit may see activity; unary units never see B valid
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (i != exp_unit && (u_a_tvalid[i] || u_b_tvalid[i] || u_r_tready[i] ||
                    (u_a_tdata[i*64 +: 64] != 64'd0) || (u_b_tdata[i*64 +: 64] != 64'd0))) begin
                    if (viol == 0) viol_msg = $sformatf("unit %0d active at %0t (expected unit %0d)", i, $time, exp_unit);
                    viol++;
                end
                if (i == exp_unit && exp_unary && u_b_tvalid[i]) begin
                    if (viol == 0) viol_msg = $sformatf("unary unit %0d saw B valid at %0t", i, $time);
                    viol++;
                end
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] d, output logic [1:0] e, output int lat);
        int n;
        int u;
        u = (op >= 3'd1 && op <= 3'd4) ? int'(op) - 1 : -1;
        @(negedge clk);
        exp_unit  = u;
        exp_unary = (u >= 0) ? TB_UNARY[u] : 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accepted", cmd_ready, 1);
        a_cyc = 0; b_cyc = 0; r_first = -1; bstab_bad = 0; lat = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (u >= 0) begin
                if (u_a_tvalid[u]) a_cyc++;
                if (u_b_tvalid[u]) begin
                    b_cyc++;
                    if (u_b_tdata[u*64 +: 64] != b) bstab_bad++;
                end
                if (u_r_tready[u] && r_first < 0) r_first = lat;
            end
        end while (!rsp_valid && lat < 100);
        check("rsp_arrived", rsp_valid, 1);
        d = rsp_data;
        e = rsp_err;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [7];
        logic [63:0] d;
        logic [63:0] ed;
        logic [1:0]  e;
        logic [1:0]  ee;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          lat;
        int          c;
        int          first;
        int          stable;
        logic        r16;
        logic        r17;

        vt[0] = '{3'd3, 64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 2'd0, 3};
        vt[1] = '{3'd1, 64'd5,                64'hDEAD,             64'd6,                2'd0, 3};
        vt[2] = '{3'd2, 64'h00FF,             64'h1234,             64'hFFFFFFFFFFFFFF00, 2'd0, 3};
        vt[3] = '{3'd4, 64'hF0F0,             64'h0FF0,             64'hFF00,             2'd0, 3};
        vt[4] = '{3'd0, 64'd1,                64'd2,                64'd0,                2'd1, 1};
        vt[5] = '{3'd7, 64'd3,                64'd4,                64'd0,                2'd1, 1};
        vt[6] = '{3'd5, 64'd3,                64'd4,                64'd0,                2'd1, 1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_unit_sigs", {u_a_tvalid, u_b_tvalid, u_r_tready}, 0);
        check("rst_idle", idle, 1);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            do_op(vt[k].op, vt[k].a, vt[k].b, d, e, lat);
            check($sformatf("vec%0d_data", k), d, vt[k].d);
            check($sformatf("vec%0d_err", k), e, vt[k].e);
            check($sformatf("vec%0d_latency", k), lat, vt[k].lat);
        end

        // Op 4 with B stalled for 5 SEND cycles
        b_lo = 5;
        do_op(3'd4, 64'h1111, 64'h2222, d, e, lat);
        check("stall_data", d, 64'h3333);
        check("stall_err", e, 0);
        check("stall_a_valid_cycles", a_cyc, 1);
        check("stall_b_valid_cycles", b_cyc, 6);
        check("stall_b_data_stable", bstab_bad, 0);
        check("stall_wait_entry", r_first, 7);
        check("stall_latency", lat, 8);
        b_lo = 0;

        rand_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (op == 3'd3) begin
                a = $realtobits(real'($urandom_range(1, 999)));
                b = $realtobits(real'($urandom_range(1, 999)) / 8.0);
            end
            ref_model(op, a, b, ed, ee);
            do_op(op, a, b, d, e, lat);
            check($sformatf("rnd%0d_op%0d_data", k, op), d, ed);
            check($sformatf("rnd%0d_op%0d_err", k, op), e, ee);
        end
        rand_mode = 1'b0;

        // Timeout: unit 2 never answers, response held off for 4 cycles
        r_en = 4'b1011;
        @(negedge clk);
        exp_unit = 2; exp_unary = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 64'h4000000000000000; cmd_b = 64'h4000000000000000;
        rsp_ready = 1'b0;
        c = 0; first = -1; r16 = 1'b0; r17 = 1'b1;
        while (first < 0 && c < 40) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            c++;
            if (c == 16) r16 = u_r_tready[2];
            if (rsp_valid) begin
                first = c;
                r17 = u_r_tready[2];
            end
        end
        check("tmo_rsp_cycle", first, 17);
        check("tmo_err", rsp_err, 2);
        check("tmo_data", rsp_data, 0);
        check("tmo_tready_before", r16, 1);
        check("tmo_tready_dropped", r17, 0);
        stable = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_err == 2'd2 && rsp_data == 64'd0 && !cmd_ready) stable++;
        end
        check("tmo_hold_stable", stable, 3);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("tmo_back_idle", idle, 1);

        // Reset while waiting for a result
        @(negedge clk);
        exp_unit = 2; exp_unary = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 64'h4000000000000000; cmd_b = 64'h4008000000000000;
        c = 0;
        while (!u_r_tready[2] && c < 20) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            c++;
        end
        check("rst_reached_wait", u_r_tready[2], 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_wait_unit_sigs", {u_a_tvalid, u_b_tvalid, u_r_tready}, 0);
        check("rst_wait_rsp_valid", rsp_valid, 0);
        check("rst_wait_idle", idle, 1);
        r_en = 4'hF;
        do_op(3'd3, 64'h4000000000000000, 64'h4008000000000000, d, e, lat);
        check("post_rst_data", d, 64'h4018000000000000);
        check("post_rst_err", e, 0);
        check("post_rst_latency", lat, 3);

        @(negedge clk);
        exp_unit = -1;
        if (viol != 0) $display("first protocol issue: %s", viol_msg);
        check("protocol_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
- Parametrised command sequencer for the FPU path: accepts one operation at a time on a valid/ready command port.
- Routes operands over AXI-stream to one of NUM_UNITS operator units (to-float, to-int, multiply, divide, and future units).
- Collects the unit's result and returns it on a valid/ready response port with an error code.
- Adds over the current fixed four-unit sequencer: configurable width, unit count and unary mask; concurrent A/B operand issue; command/response handshakes; invalid-opcode rejection; result-wait timeout.

Parameters:
- DW, 64: operand/result data width in bits.
- NUM_UNITS, 4: number of attached operator units, 1..7.
- OPW, 3: opcode width; must satisfy 2**OPW > NUM_UNITS.
- UNARY_MASK, 4'b0011: bit i=1 means unit i takes operand A only.
- TIMEOUT, 1024: cycles allowed from SEND entry to result; 0 disables timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_op  in  OPW  opcode; value k in 1..NUM_UNITS selects unit k-1.
- cmd_a  in  DW  operand A.
- cmd_b  in  DW  operand B.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
- rsp_data  out  DW  result.
- rsp_err  out  2  0=ok, 1=bad opcode, 2=timeout.
- idle  out  1  high when state IDLE and cmd_valid low.
- u_a_tdata  out  NUM_UNITS*DW  per-unit A data; unit i occupies slice [i*DW +: DW].
- u_a_tvalid  out  NUM_UNITS  per-unit A valid.
- u_a_tready  in  NUM_UNITS  per-unit A ready.
- u_b_tdata  out  NUM_UNITS*DW  per-unit B data.
- u_b_tvalid  out  NUM_UNITS  per-unit B valid.
- u_b_tready  in  NUM_UNITS  per-unit B ready.
- u_r_tdata  in  NUM_UNITS*DW  per-unit result data.
- u_r_tvalid  in  NUM_UNITS  per-unit result valid.
- u_r_tready  out  NUM_UNITS  per-unit result ready.

Behaviour:
- Reset values: state IDLE; all u_*_tvalid and u_r_tready 0; rsp_valid 0; rsp_data 0; rsp_err 0; timeout counter 0.
- Reset is synchronous and overrides any in-flight operation; the pending operation is discarded and no response is produced.
- Unselected units always see tvalid=0, tready=0 and tdata=0.
- States: IDLE, SEND, WAIT, RESP.
- IDLE:
  - cmd_ready=1 combinationally.
  - On cmd handshake, register op, A and B.
  - Valid op: go to SEND and clear the timeout counter.
  - op=0 or op>NUM_UNITS: go to RESP with rsp_err=1, rsp_data=0. rsp_valid is high the cycle after accept.
- SEND:
  - A valid is high from the first SEND cycle. B valid is high at the same time unless UNARY_MASK[unit]=1.
  - Each valid drops the cycle after its own handshake; A and B complete independently, in any order or in the same cycle.
  - Go to WAIT the cycle after both are done (unary: A only).
- WAIT:
  - u_r_tready[unit]=1.
  - On handshake, capture u_r_tdata into rsp_data, set rsp_err=0, drop tready, go to RESP.
- RESP:
  - rsp_valid=1 with rsp_data/rsp_err held stable until rsp_ready; return to IDLE the cycle after the handshake.
  - cmd_ready=0 throughout RESP.
- Timeout:
  - The counter increments each cycle in SEND and WAIT.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without completion, the next cycle drops all unit valids/readys and enters RESP with rsp_err=2, rsp_data=0.
  - A late result from a timed-out unit is not drained. It stays pending at that unit; recovery is the caller's responsibility (reset).
- Minimum latency, valid op, all readys high and result ready immediately:
  - accept at cycle 0;
  - A/B handshake at cycle 1;
  - result handshake at cycle 2;
  - rsp_valid at cycle 3.
- Command/response is strictly one outstanding operation; a back-to-back command is accepted no earlier than the cycle after the response handshake.

Test Plan:
- Binary op 3 (multiply, unit 2), A=0x4000000000000000, B=0x4008000000000000, unit readys high, result 0x4018000000000000 one cycle after tready -> rsp_valid at cycle 3, rsp_data=0x4018000000000000, rsp_err=0, only unit 2 signals toggle.
- Unary op 1, A=5, B=0xDEAD -> u_b_tvalid never asserted for any unit; rsp_data equals the unit-0 result.
- Op 4 with u_b_tready held low 5 cycles after A accepted -> u_a_tvalid drops after 1 cycle, u_b_tvalid held 6 cycles with stable data, WAIT entered only after the B handshake.
- cmd_op=0 and cmd_op=7 -> response the cycle after accept with rsp_err=1, rsp_data=0, no unit valid asserted.
- TIMEOUT=16, unit never raises result valid -> exactly 16 cycles after SEND entry rsp_err=2 asserted and u_r_tready dropped; rsp_ready held low 4 cycles keeps rsp_valid/rsp_err stable.
- Reset asserted during WAIT -> next cycle all valids/readys 0, rsp_valid 0, idle=1 once cmd_valid is low; a new command then completes normally.
